// File: rtl/run_detector_param.sv
// Detects a run of LEN identical bits on a valid-qualified serial input, with
// fill gating, overlap control, per-polarity enables and a saturating match counter.
module run_detector_param #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             w,
  input  logic             clear,
  input  logic             overlap,
  input  logic             en_ones,
  input  logic             en_zeros,
  output logic             z,
  output logic             z_ones,
  output logic             z_zeros,
  output logic [CNT_W-1:0] match_count,
  output logic             fill_done
);

  localparam int                FILL_W   = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [LEN-1:0]    history_r;
  logic [FILL_W-1:0] fill_r;
  logic              z_r;
  logic              z_ones_r;
  logic              z_zeros_r;
  logic              fill_done_r;
  logic [CNT_W-1:0]  match_count_r;

  logic [LEN-1:0]    hist_shift_s;
  logic [FILL_W-1:0] fill_inc_s;
  logic              ones_hit_s;
  logic              zeros_hit_s;
  logic              match_s;
  logic [LEN-1:0]    history_nxt_s;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;

  // Candidate history/fill for a valid sample and the resulting match decision
  always_comb begin
    hist_shift_s = {history_r[LEN-2:0], w};
    fill_inc_s   = fill_r;
    if (fill_r != FILL_MAX) begin
      fill_inc_s = fill_r + FILL_W'(1);
    end else begin
      fill_inc_s = fill_r;
    end
    // in_valid gating keeps an unknown w on idle cycles away from the hit terms
    ones_hit_s  = in_valid & ~clear & en_ones  & (fill_inc_s == FILL_MAX) & (&hist_shift_s);
    zeros_hit_s = in_valid & ~clear & en_zeros & (fill_inc_s == FILL_MAX) & ~(|hist_shift_s);
    match_s     = ones_hit_s | zeros_hit_s;
  end

  // Next-state selection for history, fill and the saturating counter
  always_comb begin
    history_nxt_s = history_r;
    fill_nxt_s    = fill_r;
    count_nxt_s   = match_count_r;
    if (clear) begin
      history_nxt_s = {LEN{1'b0}};
      fill_nxt_s    = {FILL_W{1'b0}};
      count_nxt_s   = {CNT_W{1'b0}};
    end else if (in_valid) begin
      history_nxt_s = hist_shift_s;
      if (match_s && !overlap) begin
        fill_nxt_s = {FILL_W{1'b0}};
      end else begin
        fill_nxt_s = fill_inc_s;
      end
      if (match_s && (match_count_r != CNT_MAX)) begin
        count_nxt_s = match_count_r + CNT_W'(1);
      end else begin
        count_nxt_s = match_count_r;
      end
    end else begin
      history_nxt_s = history_r;
      fill_nxt_s    = fill_r;
      count_nxt_s   = match_count_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history_r     <= {LEN{1'b0}};
      fill_r        <= {FILL_W{1'b0}};
      z_r           <= 1'b0;
      z_ones_r      <= 1'b0;
      z_zeros_r     <= 1'b0;
      fill_done_r   <= 1'b0;
      match_count_r <= {CNT_W{1'b0}};
    end else begin
      history_r     <= history_nxt_s;
      fill_r        <= fill_nxt_s;
      z_r           <= match_s;
      z_ones_r      <= ones_hit_s;
      z_zeros_r     <= zeros_hit_s;
      fill_done_r   <= (fill_nxt_s == FILL_MAX);
      match_count_r <= count_nxt_s;
    end
  end

  assign z           = z_r;
  assign z_ones      = z_ones_r;
  assign z_zeros     = z_zeros_r;
  assign fill_done   = fill_done_r;
  assign match_count = match_count_r;

endmodule

// File: tb/tb_run_detector_param.sv
// Directed table-driven bench for run_detector_param (LEN=4), with a CNT_W=2
// twin sharing the same stimulus for counter saturation.
module tb_run_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, w, clear, overlap, en_ones, en_zeros;
  logic       z, z_ones, z_zeros, fill_done;
  logic [7:0] match_count;
  logic       z2, z_ones2, z_zeros2, fill_done2;
  logic [1:0] match_count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  run_detector_param #(.LEN(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .w(w), .clear(clear),
    .overlap(overlap), .en_ones(en_ones), .en_zeros(en_zeros),
    .z(z), .z_ones(z_ones), .z_zeros(z_zeros),
    .match_count(match_count), .fill_done(fill_done)
  );

  run_detector_param #(.LEN(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .w(w), .clear(clear),
    .overlap(overlap), .en_ones(en_ones), .en_zeros(en_zeros),
    .z(z2), .z_ones(z_ones2), .z_zeros(z_zeros2),
    .match_count(match_count2), .fill_done(fill_done2)
  );

  typedef struct {
    logic       clr;
    logic       vld;
    logic       wb;
    logic       ovl;
    logic       eo;
    logic       ez;
    logic       x_ones;
    logic       x_zeros;
    logic       x_fd;
    logic [7:0] x_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, v, wb, o, eo, ez, xo, xz, fd, input int cnt);
    vec_t t;
    t = '{clr: c, vld: v, wb: wb, ovl: o, eo: eo, ez: ez,
          x_ones: xo, x_zeros: xz, x_fd: fd, x_cnt: 8'(cnt)};
    vecs.push_back(t);
  endtask

  task automatic step(input logic c, v, wb, o, eo, ez);
    clear = c; in_valid = v; w = wb; overlap = o; en_ones = eo; en_zeros = ez;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic xo, xz, fd, input logic [7:0] cnt);
    logic xz_any;
    xz_any = xo | xz;
    n_vec++;
    if (z !== xz_any || z_ones !== xo || z_zeros !== xz || fill_done !== fd || match_count !== cnt) begin
      n_err++;
      $display("FAIL %s: got z=%b z_ones=%b z_zeros=%b fill_done=%b count=%0d, want z=%b z_ones=%b z_zeros=%b fill_done=%b count=%0d",
               nm, z, z_ones, z_zeros, fill_done, match_count, xz_any, xo, xz, fd, cnt);
    end
  endtask

  task automatic check_sat(input string nm, input logic [1:0] cnt);
    n_vec++;
    if (match_count2 !== cnt) begin
      n_err++;
      $display("FAIL %s: got count2=%0d, want %0d", nm, match_count2, cnt);
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; w = 1'b0;
    overlap = 1'b1; en_ones = 1'b1; en_zeros = 1'b1;

    // Fill gating then overlapping run of 7 ones
    for (int i = 0; i < 3; i++) add(0,1,1,1,1,1, 0,0,0, 0);
    for (int i = 1; i <= 4; i++) add(0,1,1,1,1,1, 1,0,1, i);
    // Clear with valid: sample dropped
    add(1,1,1,1,1,1, 0,0,0, 0);
    // Non-overlapping: 8 ones -> pulses on 4 and 8
    for (int i = 0; i < 3; i++) add(0,1,1,0,1,1, 0,0,0, 0);
    add(0,1,1,0,1,1, 1,0,0, 1);
    for (int i = 0; i < 3; i++) add(0,1,1,0,1,1, 0,0,0, 1);
    add(0,1,1,0,1,1, 1,0,0, 2);
    add(0,0,1'bx,0,1,1, 0,0,0, 2);
    add(1,0,0,1,0,1, 0,0,0, 0);
    // Zeros only: 1111 0000 -> zeros pulse on sample 8
    for (int i = 0; i < 3; i++) add(0,1,1,1,0,1, 0,0,0, 0);
    add(0,1,1,1,0,1, 0,0,1, 0);
    for (int i = 0; i < 3; i++) add(0,1,0,1,0,1, 0,0,1, 0);
    add(0,1,0,1,0,1, 0,1,1, 1);
    // Disable zeros mid-run: suppressed, then re-enabled matches without refill
    add(0,1,0,1,0,0, 0,0,1, 1);
    add(0,1,0,1,0,1, 0,1,1, 2);
    add(1,0,0,1,1,1, 0,0,0, 0);
    // Valid gaps with unknown w while idle
    for (int i = 0; i < 2; i++) add(0,1,1,1,1,1, 0,0,0, 0);
    for (int i = 0; i < 5; i++) add(0,0,1'bx,1,1,1, 0,0,0, 0);
    add(0,1,1,1,1,1, 0,0,0, 0);
    add(0,1,1,1,1,1, 1,0,1, 1);
    // Clear with valid drops the sample; next match needs 4 fresh samples
    add(1,0,0,1,1,1, 0,0,0, 0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,1,1, 0,0,0, 0);
    add(1,1,1,1,1,1, 0,0,0, 0);
    for (int i = 0; i < 3; i++) add(0,1,1,1,1,1, 0,0,0, 0);
    add(0,1,1,1,1,1, 1,0,1, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, 0, 0, 8'd0);
    check_sat("reset_state_sat", 2'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].vld, vecs[i].wb, vecs[i].ovl, vecs[i].eo, vecs[i].ez);
      check($sformatf("vec[%0d]", i), vecs[i].x_ones, vecs[i].x_zeros, vecs[i].x_fd, vecs[i].x_cnt);
    end

    // Break the run with a 0, then 3 ones (no match), then async reset off-edge
    step(0,1,0,1,1,1); check("break_zero", 0, 0, 1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step(0,1,1,1,1,1); check($sformatf("pre_reset_%0d", i), 0, 0, 1, 8'd1);
    end
    #2 reset = 1'b0;
    #1 check("async_reset", 0, 0, 0, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0,1,1,1,1,1); check($sformatf("post_reset_%0d", i), 0, 0, 0, 8'd0);
    end
    step(0,1,1,1,1,1); check("post_reset_match", 1, 0, 1, 8'd1);

    // Saturation: 6 non-overlapping matches; 2-bit counter sticks at 3
    step(1,0,0,0,1,1); check("sat_clear", 0, 0, 0, 8'd0);
    for (int m = 1; m <= 6; m++) begin
      for (int i = 0; i < 3; i++) step(0,1,1,0,1,1);
      step(0,1,1,0,1,1);
      check($sformatf("sat_match_%0d", m), 1, 0, 0, 8'(m));
      check_sat($sformatf("sat_count2_%0d", m), (m > 3) ? 2'd3 : 2'(m));
    end
    step(1,1,1,0,1,1);
    check("sat_clear_valid", 0, 0, 0, 8'd0);
    check_sat("sat_clear_valid2", 2'd0);

    step(0,0,0,1,1,1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/run_detector_param.md
Name: run_detector_param

Overview:
- Parametrised successor to the fixed 4-bit 0000/1111 detector.
- Detects a run of LEN consecutive identical bits (all-ones and/or all-zeros) on a serial input qualified by a valid strobe.
- Adds explicit history-fill gating, overlapping/non-overlapping modes, per-polarity enables and a saturating match counter.
- Sits between the serial line front end and the status/interrupt logic.

Parameters:
- LEN, 4, run length to detect; legal range 2..32.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  w is sampled on this cycle
- w  in  1  serial data bit
- clear  in  1  synchronous flush of history, fill count and match counter
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- en_ones  in  1  enable detection of a run of ones
- en_zeros  in  1  enable detection of a run of zeros
- z  out  1  one-cycle match pulse (either polarity)
- z_ones  out  1  match pulse, ones run
- z_zeros  out  1  match pulse, zeros run
- match_count  out  CNT_W  saturating count of matches since reset/clear
- fill_done  out  1  history holds LEN valid samples

Behaviour:
- Reset (reset=0, asynchronous):
  - history=0, fill=0.
  - z, z_ones, z_zeros, fill_done = 0; match_count=0.
  - Release is synchronous to clk; the first sample is taken on the first in_valid after release.
- History register:
  - LEN bits; on in_valid, history <= {history[LEN-2:0], w}.
  - When in_valid=0, history and fill hold.
- Fill counter:
  - Range 0..LEN; increments on in_valid and saturates at LEN.
  - fill_done = (fill==LEN), registered.
  - Replaces the old preset-seed trick: no match is possible until LEN real samples have been taken.
- Match evaluation:
  - Evaluated on a cycle with in_valid=1, using the next history value (the value including the current w).
  - Next fill must reach LEN for a match to count.
  - ones_hit = en_ones & next history all 1s; zeros_hit = en_zeros & next history all 0s.
- Outputs:
  - Registered; z_ones/z_zeros pulse high for exactly one cycle on the clock edge that shifts in the completing bit.
  - Observable one cycle after the sampling edge's inputs are presented; latency 1 clk from the completing sample.
  - z = z_ones | z_zeros. Both cannot be high together, since LEN>=2.
  - All three outputs are 0 on any cycle without a match, including in_valid=0 cycles.
- overlap=1: fill stays at LEN after a match. A continuing run pulses z on every further valid sample.
- overlap=0: on a match, fill is forced to 0. The next match needs LEN fresh samples; history contents are don't-care once fill is reset.
- Mode and enable inputs:
  - overlap, en_ones and en_zeros are sampled every cycle; changes take effect on the next valid sample.
  - Disabling a polarity mid-run suppresses its match but does not reset fill.
- match_count:
  - Increments by 1 per match pulse.
  - Saturates at 2^CNT_W-1 and does not wrap.
- clear:
  - clear=1 at a clock edge zeroes history, fill, fill_done and match_count.
  - It forces z* to 0 for that edge.
  - clear with simultaneous in_valid: clear wins and the sample is discarded.
- Reset mid-run aborts immediately; a partial run never produces a match after release.
- X on w while in_valid=0 must not propagate.

Test Plan (LEN=4, CNT_W=8 unless stated):
- Fill gating: release reset, drive w=1 for 3 valid cycles -> z=0, fill_done=0. 4th valid 1 -> z_ones pulse 1 cycle, fill_done=1, match_count=1.
- Overlap: overlap=1, 7 consecutive valid 1s -> z_ones pulses on samples 4,5,6,7; match_count=4. Same stream with overlap=0 -> pulse on sample 4 only; match_count=1. An 8th 1 -> second pulse; count=2.
- Zeros/enables: en_zeros=1, en_ones=0, stream 1111 0000 -> z_ones never high; z_zeros pulses on sample 8 only; z tracks z_zeros.
- Valid gaps: stream 1,1,(in_valid=0 for 5 cycles, w=X),1,1 -> single z_ones on the 4th valid sample; no X on outputs.
- Saturation/clear: CNT_W=2, 6 non-overlapping ones-matches -> match_count sticks at 3. Assert clear together with in_valid -> count=0, fill_done=0, sample dropped; the next match needs 4 fresh samples.
- Async reset mid-run: after 3 valid 1s, pulse reset low off-edge -> all outputs 0 immediately. After release, 1 more valid 1 gives no match; 4 valid 1s give one match.
